// File: rtl/ibr128_pkg.sv
// rtl/ibr128_pkg.sv - IBR128 packer widths, state encoding and pad constant (IBR128_PKCS7_PAD_EN)
package ibr128_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    PAD   = 2'd1,
    ISSUE = 2'd2,
    GAP   = 2'd3
  } packer_state_e;

`ifdef IBR128_PKCS7_PAD_EN
  // Extra block appended after a message that ends exactly on a block boundary.
  localparam logic [BLOCK_W-1:0] PAD_FULL_BLOCK = {16{8'h10}};
`endif

endpackage

// File: rtl/ibr128_block_packer_if.sv
// rtl/ibr128_block_packer_if.sv - word stream in, plaintext block and core handshake out
interface ibr128_block_packer_if;
  import ibr128_pkg::*;

  logic [WORD_W-1:0]  inData;
  logic               inValid;
  logic               inLast;
  logic [2:0]         inBytes;
  logic               inReady;
  logic [BLOCK_W-1:0] plainText;
  logic               Enable;
  logic               FB;
  logic               cipherReady;
  logic               msgDone;

  // Packer side: consumes words, drives the cipher core inputs.
  modport master (
    input  inData, inValid, inLast, inBytes, cipherReady,
    output inReady, plainText, Enable, FB, msgDone
  );

  // Environment side: word source plus cipher core.
  modport slave (
    output inData, inValid, inLast, inBytes, cipherReady,
    input  inReady, plainText, Enable, FB, msgDone
  );

endinterface

// File: rtl/ibr128_pad_gen.sv
// rtl/ibr128_pad_gen.sv - fills bytes n..15 of a block with PKCS#7 pad or zeros (IBR128_PKCS7_PAD_EN)
module ibr128_pad_gen (
  input  logic [127:0] i_block,
  input  logic [3:0]   i_n,
  output logic [127:0] o_block
);
  import ibr128_pkg::*;

  logic [7:0] w_fill;

`ifdef IBR128_PKCS7_PAD_EN
  assign w_fill = 8'd16 - {4'd0, i_n};
`else
  assign w_fill = 8'd0;
`endif

  // n = 0 means the data already fills the block, so nothing is overwritten.
  always_comb begin
    o_block = i_block;
    for (int b = 0; b < 16; b++) begin
      if (i_n != 4'd0 && 4'(b) >= i_n) begin
        o_block[BLOCK_W-1-8*b -: 8] = w_fill;
      end
    end
  end

endmodule

// File: rtl/ibr128_block_packer.sv
// rtl/ibr128_block_packer.sv - packs 32-bit words into 128-bit blocks for the IBR128 core (IBR128_PKCS7_PAD_EN)
module ibr128_block_packer #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 128
) (
  input logic                   Clk,
  input logic                   RstN,
  ibr128_block_packer_if.master bus
);
  import ibr128_pkg::*;

  packer_state_e      r_state;
  logic [BLOCK_W-1:0] r_buf;
  logic [BLOCK_W-1:0] r_plain;
  logic [1:0]         r_wcnt;
  logic [3:0]         r_n;
  logic               r_final;
  logic               r_fb;
  logic               r_enable;
  logic               r_in_ready;
  logic               r_msg_done;
`ifdef IBR128_PKCS7_PAD_EN
  logic               r_pad_pending;
`endif

  logic               w_accept;
  logic [2:0]         w_eff_bytes;
  logic [3:0]         w_n;
  logic [BLOCK_W-1:0] w_buf_next;
  logic [BLOCK_W-1:0] w_padded;

  assign w_accept    = bus.inValid && r_in_ready;
  // Zero and out-of-range byte counts mean a full last word.
  assign w_eff_bytes = (bus.inBytes == 3'd0 || bus.inBytes > 3'd4) ? 3'd4 : bus.inBytes;
  // Wraps to 0 when the last word lands in slot 3 with four bytes.
  assign w_n         = {r_wcnt, 2'b00} + {1'b0, w_eff_bytes};

  // Buffer with the incoming word dropped into its slot; slot 0 is the MSB word.
  always_comb begin
    w_buf_next = r_buf;
    case (r_wcnt)
      2'd0:    w_buf_next[BLOCK_W-1          -: WORD_W] = bus.inData;
      2'd1:    w_buf_next[BLOCK_W-1-WORD_W   -: WORD_W] = bus.inData;
      2'd2:    w_buf_next[BLOCK_W-1-2*WORD_W -: WORD_W] = bus.inData;
      default: w_buf_next[WORD_W-1:0]                   = bus.inData;
    endcase
  end

  ibr128_pad_gen u_pad_gen (
    .i_block (r_buf),
    .i_n     (r_n),
    .o_block (w_padded)
  );

  // Packer FSM: fill slots, pad the final block, hold it for the core, then one idle gap.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      r_state       <= FILL;
      r_buf         <= '0;
      r_plain       <= '0;
      r_wcnt        <= 2'd0;
      r_n           <= 4'd0;
      r_final       <= 1'b0;
      r_fb          <= 1'b1;
      r_enable      <= 1'b0;
      r_in_ready    <= 1'b0;
      r_msg_done    <= 1'b0;
`ifdef IBR128_PKCS7_PAD_EN
      r_pad_pending <= 1'b0;
`endif
    end else begin
      r_msg_done <= 1'b0;
      case (r_state)
        FILL: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_buf  <= w_buf_next;
            r_wcnt <= r_wcnt + 2'd1;
            if (bus.inLast) begin
              r_n        <= w_n;
              r_final    <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= PAD;
            end else if (r_wcnt == 2'd3) begin
              r_plain    <= w_buf_next;
              r_enable   <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= ISSUE;
            end
          end
        end
        PAD: begin
          r_plain  <= w_padded;
          r_enable <= 1'b1;
`ifdef IBR128_PKCS7_PAD_EN
          r_pad_pending <= (r_n == 4'd0);
`endif
          r_state  <= ISSUE;
        end
        ISSUE: begin
          if (bus.cipherReady) begin
            r_enable   <= 1'b0;
`ifdef IBR128_PKCS7_PAD_EN
            r_msg_done <= r_final && !r_pad_pending;
`else
            r_msg_done <= r_final;
`endif
            r_state    <= GAP;
          end
        end
        GAP: begin
          r_fb <= r_msg_done;
`ifdef IBR128_PKCS7_PAD_EN
          if (r_pad_pending) begin
            r_pad_pending <= 1'b0;
            r_plain       <= PAD_FULL_BLOCK;
            r_enable      <= 1'b1;
            r_state       <= ISSUE;
          end else begin
            r_wcnt     <= 2'd0;
            r_final    <= 1'b0;
            r_in_ready <= 1'b1;
            r_state    <= FILL;
          end
`else
          r_wcnt     <= 2'd0;
          r_final    <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= FILL;
`endif
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.inReady   = r_in_ready;
  assign bus.plainText = r_plain;
  assign bus.Enable    = r_enable;
  assign bus.FB        = r_fb;
  assign bus.msgDone   = r_msg_done;

endmodule
